// File: rtl/multi_shift_register.sv
// Multi-function shift register: single-step load/shift/rotate ops in IDLE,
// plus counted multi-step shifts (IDLE -> RUN -> FIN) with busy/done flags.
module multi_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] qout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  logic [2:0]       opMode;
  logic [WIDTH-1:0] stepVal;
  logic             stepOut;
  logic             isShiftCmd;

  // One shared step datapath; RUN uses the latched mode, IDLE the live one.
  always_comb begin
    opMode  = (state_q == RUN) ? mode_q : mode;
    stepVal = qout_q;
    stepOut = sout_q;
    case (opMode)
      3'b010: begin
        stepVal = {qout_q[WIDTH-2:0], sin};
        stepOut = qout_q[WIDTH-1];
      end
      3'b011: begin
        stepVal = {sin, qout_q[WIDTH-1:1]};
        stepOut = qout_q[0];
      end
      3'b100: begin
        stepVal = {qout_q[WIDTH-2:0], qout_q[WIDTH-1]};
        stepOut = qout_q[WIDTH-1];
      end
      3'b101: begin
        stepVal = {qout_q[0], qout_q[WIDTH-1:1]};
        stepOut = qout_q[0];
      end
      3'b110: begin
        stepVal = {qout_q[WIDTH-1], qout_q[WIDTH-1:1]};
        stepOut = qout_q[0];
      end
      default: begin
        stepVal = qout_q;
        stepOut = sout_q;
      end
    endcase
  end

  assign isShiftCmd = (mode >= 3'b010) && (mode <= 3'b110);

  always_comb begin
    state_d = state_q;
    qout_d  = qout_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (start && isShiftCmd) begin
            mode_d  = mode;
            cnt_d   = amt;
            state_d = RUN;
          end else if (mode == 3'b001) begin
            qout_d = din;
          end else if (isShiftCmd) begin
            qout_d = stepVal;
            sout_d = stepOut;
          end
        end
      end
      RUN: begin
        if (en) begin
          if (cnt_q != '0) begin
            qout_d = stepVal;
            sout_d = stepOut;
            cnt_d  = cnt_q - CNT_W'(1);
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flags follow the next state so they stay registered yet exact.
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      qout_q  <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      qout_q  <= qout_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign qout = qout_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
